// File: rtl/sum_ram_rdout.sv
// Sum RAM drain stage: credit-limited read sequencing, in-flight tracking, small FIFO,
// then rounding shift / ReLU / saturation into a valid/ready output register.
//
// state   | meaning
// S_IDLE  | waiting for I_start; parameters latched on accept
// S_READ  | issuing reads 0..len-1 as credit allows
// S_DRAIN | all reads issued; waiting for the last word to transfer
// S_DONE  | one-cycle O_done pulse, then back to idle
module sum_ram_rdout #(
  parameter int C_DSIZE  = 24,
  parameter int C_ASIZE  = 10,
  parameter int C_OSIZE  = 8,
  parameter int C_SHW    = 5,
  parameter int C_RD_LAT = 2
) (
  input  logic               I_clk,
  input  logic               I_rst_n,
  input  logic               I_start,
  input  logic [C_ASIZE:0]   I_len,
  input  logic [C_SHW-1:0]   I_shift,
  input  logic               I_relu_en,
  output logic               O_rd_en,
  output logic [C_ASIZE-1:0] O_raddr,
  input  logic [C_DSIZE-1:0] I_rdata,
  output logic               O_dv,
  input  logic               I_rdy,
  output logic [C_OSIZE-1:0] O_dout,
  output logic               O_busy,
  output logic               O_done
);

  localparam int DEPTH = C_RD_LAT + 2;
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW    = $clog2(DEPTH + 1) + 1;
  localparam int W     = C_DSIZE + 1;
  localparam int LW    = C_ASIZE + 1;
  localparam logic signed [W-1:0] C_MAX = W'((1 << (C_OSIZE - 1)) - 1);
  localparam logic signed [W-1:0] C_MIN = ~C_MAX;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

  state_t r_state, w_next;

  logic [LW-1:0]      r_len;
  logic [C_SHW-1:0]   r_shift;
  logic               r_relu;
  logic [C_ASIZE-1:0] r_raddr;
  logic [LW-1:0]      r_xfer_cnt;
  logic [C_RD_LAT-1:0] r_vld;
  logic [C_DSIZE-1:0] r_mem [DEPTH];
  logic [PW-1:0]      r_wptr, r_rptr;
  logic [CW-1:0]      r_cnt;
  logic               r_dv;
  logic [C_OSIZE-1:0] r_dout;

  logic               w_start_ok;
  logic [CW-1:0]      w_infl;
  logic               w_credit;
  logic               w_rd_en;
  logic               w_last_rd;
  logic               w_tail;
  logic               w_empty;
  logic [C_DSIZE-1:0] w_head;
  logic               w_head_vld;
  logic               w_xfer;
  logic               w_load;
  logic               w_pop;
  logic               w_push;
  logic               w_last_xfer;
  logic signed [W-1:0] w_x, w_rnd, w_sum, w_sh, w_relu;
  logic [C_OSIZE-1:0] w_sat;

  always_comb begin
    w_infl = '0;
    for (int i = 0; i < C_RD_LAT; i++) w_infl = w_infl + CW'(r_vld[i]);
  end

  assign w_start_ok  = (r_state == S_IDLE) && I_start;
  assign w_credit    = (r_cnt + w_infl) < CW'(DEPTH);
  assign w_rd_en     = (r_state == S_READ) && w_credit;
  assign w_last_rd   = w_rd_en && (({1'b0, r_raddr} + LW'(1)) == r_len);
  assign w_tail      = r_vld[C_RD_LAT-1];
  assign w_empty     = (r_cnt == '0);
  // An empty FIFO is bypassed so arriving data can load the output register directly.
  assign w_head      = w_empty ? I_rdata : r_mem[r_rptr];
  assign w_head_vld  = !w_empty || w_tail;
  assign w_xfer      = r_dv && I_rdy;
  assign w_load      = w_head_vld && (!r_dv || I_rdy);
  assign w_pop       = w_load && !w_empty;
  assign w_push      = w_tail && !(w_empty && w_load);
  assign w_last_xfer = w_xfer && ((r_xfer_cnt + LW'(1)) == r_len);

  // FSM: state register
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // FSM: next state
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (I_start) w_next = (I_len == '0) ? S_DONE : S_READ;
      S_READ:  if (w_last_rd) w_next = S_DRAIN;
      S_DRAIN: if (w_last_xfer) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    O_rd_en = w_rd_en;
    O_busy  = (r_state != S_IDLE);
    O_done  = (r_state == S_DONE);
  end

  assign O_raddr = r_raddr;
  assign O_dv    = r_dv;
  assign O_dout  = r_dout;

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      r_len      <= '0;
      r_shift    <= '0;
      r_relu     <= 1'b0;
      r_raddr    <= '0;
      r_xfer_cnt <= '0;
    end else if (w_start_ok) begin
      r_len      <= I_len;
      r_shift    <= I_shift;
      r_relu     <= I_relu_en;
      r_raddr    <= '0;
      r_xfer_cnt <= '0;
    end else begin
      if (w_rd_en && !w_last_rd) r_raddr <= r_raddr + C_ASIZE'(1);
      if (w_xfer) r_xfer_cnt <= r_xfer_cnt + LW'(1);
    end
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      r_vld <= '0;
    end else begin
      r_vld[0] <= w_rd_en;
      for (int i = 1; i < C_RD_LAT; i++) r_vld[i] <= r_vld[i-1];
    end
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= I_rdata;
        r_wptr <= (r_wptr == PW'(DEPTH - 1)) ? '0 : r_wptr + PW'(1);
      end
      if (w_pop) r_rptr <= (r_rptr == PW'(DEPTH - 1)) ? '0 : r_rptr + PW'(1);
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
    end
  end

  // One guard bit keeps the rounding add from overflowing.
  assign w_x    = {w_head[C_DSIZE-1], w_head};
  assign w_rnd  = (r_shift == '0) ? '0 : (W'(1) << (r_shift - C_SHW'(1)));
  assign w_sum  = w_x + w_rnd;
  assign w_sh   = w_sum >>> r_shift;
  assign w_relu = (r_relu && w_sh[W-1]) ? '0 : w_sh;

  always_comb begin
    w_sat = w_relu[C_OSIZE-1:0];
    if (w_relu > C_MAX)      w_sat = C_MAX[C_OSIZE-1:0];
    else if (w_relu < C_MIN) w_sat = C_MIN[C_OSIZE-1:0];
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      r_dv   <= 1'b0;
      r_dout <= '0;
    end else if (w_load) begin
      r_dv   <= 1'b1;
      r_dout <= w_sat;
    end else if (w_xfer) begin
      r_dv   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sum_ram_rdout.sv
// Randomized bench for sum_ram_rdout: RAM model with fixed read latency, arithmetic
// reference for the post-processing, and a negedge monitor checking order and stalls.
module tb_sum_ram_rdout;
  localparam int DS = 24, AS = 10, OS = 8, SHW = 5, LAT = 2;
  localparam int DEPTH = LAT + 2;

  logic          I_clk = 1'b0;
  logic          I_rst_n = 1'b0;
  logic          I_start = 1'b0;
  logic [AS:0]   I_len = '0;
  logic [SHW-1:0] I_shift = '0;
  logic          I_relu_en = 1'b0;
  logic          O_rd_en;
  logic [AS-1:0] O_raddr;
  logic [DS-1:0] I_rdata;
  logic          O_dv;
  logic          I_rdy = 1'b0;
  logic [OS-1:0] O_dout;
  logic          O_busy, O_done;

  sum_ram_rdout #(.C_DSIZE(DS), .C_ASIZE(AS), .C_OSIZE(OS), .C_SHW(SHW), .C_RD_LAT(LAT)) dut (
    .I_clk(I_clk), .I_rst_n(I_rst_n), .I_start(I_start), .I_len(I_len),
    .I_shift(I_shift), .I_relu_en(I_relu_en), .O_rd_en(O_rd_en), .O_raddr(O_raddr),
    .I_rdata(I_rdata), .O_dv(O_dv), .I_rdy(I_rdy), .O_dout(O_dout),
    .O_busy(O_busy), .O_done(O_done)
  );

  always #5 I_clk = ~I_clk;

  int n_tests = 0, n_fail = 0;

  task automatic check_val(input string tag, input longint obs, input longint exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint ref_pp(input longint x, input int sh, input bit relu);
    longint v;
    v = x;
    if (sh > 0) v = (v + (longint'(1) <<< (sh - 1))) >>> sh;
    if (relu && v < 0) v = 0;
    if (v > 127) v = 127;
    if (v < -128) v = -128;
    return v;
  endfunction

  // sum RAM model with LAT-cycle read latency
  logic signed [DS-1:0] ram [0:1023];
  logic [DS-1:0] rd_pipe [LAT];
  always @(posedge I_clk) begin
    rd_pipe[0] <= O_rd_en ? ram[O_raddr] : '0;
    for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign I_rdata = rd_pipe[LAT-1];

  int rdy_mode = 0;
  always @(posedge I_clk) begin
    #1;
    case (rdy_mode)
      0:       I_rdy = 1'b1;
      1:       I_rdy = 1'($urandom_range(0, 1));
      default: I_rdy = 1'b0;
    endcase
  end

  int cyc = 0;
  always @(posedge I_clk) cyc <= cyc + 1;

  int cur_len = 0, cur_shift = 0;
  bit cur_relu = 0;
  int n_rd = 0, n_xfer = 0, n_done = 0;
  int rd_idx = 0, x_idx = 0;
  int first_rd_cyc = 0, first_dv_cyc = 0, last_xfer_cyc = 0, done_cyc = 0;
  bit dv_seen = 0, prev_stall = 0;
  logic [OS-1:0] prev_dout = '0;

  always @(negedge I_clk) begin
    if (!I_rst_n) begin
      rd_idx = 0; x_idx = 0; dv_seen = 0; prev_stall = 0;
    end else begin
      if (prev_stall) begin
        check_val("stall_dv", longint'(O_dv), 1);
        check_val("stall_dout", longint'(O_dout), longint'(prev_dout));
      end
      if (O_rd_en) begin
        if (rd_idx == 0) first_rd_cyc = cyc;
        check_val("raddr", longint'(O_raddr), rd_idx);
        check_val("credit", longint'((rd_idx + 1 - x_idx) <= DEPTH + 1), 1);
        rd_idx++; n_rd++;
      end
      if (O_dv && !dv_seen) begin dv_seen = 1; first_dv_cyc = cyc; end
      if (O_dv && I_rdy) begin
        if (x_idx < cur_len)
          check_val("dout", longint'($signed(O_dout)), ref_pp(longint'(ram[x_idx]), cur_shift, cur_relu));
        else
          check_val("extra_word", x_idx, cur_len);
        x_idx++; n_xfer++; last_xfer_cyc = cyc;
      end
      prev_stall = O_dv && !I_rdy;
      prev_dout  = O_dout;
      if (O_done) begin
        n_done++; done_cyc = cyc; rd_idx = 0; x_idx = 0; dv_seen = 0;
      end
    end
  end

  int base_rd = 0, base_x = 0, base_done = 0, start_cyc = 0;

  task automatic pulse_start(input int len, input int sh, input bit relu);
    @(posedge I_clk); #1;
    I_start = 1'b1; I_len = (AS+1)'(len); I_shift = SHW'(sh); I_relu_en = relu;
    start_cyc = cyc;
    @(posedge I_clk); #1;
    I_start = 1'b0;
    I_len = (AS+1)'($urandom_range(0, 50)); I_shift = SHW'($urandom); I_relu_en = 1'($urandom);
  endtask

  task automatic start_drain(input int len, input int sh, input bit relu);
    cur_len = len; cur_shift = sh; cur_relu = relu;
    base_rd = n_rd; base_x = n_xfer; base_done = n_done;
    pulse_start(len, sh, relu);
  endtask

  task automatic wait_done(input int budget);
    int k;
    k = 0;
    while (n_done == base_done && k < budget) begin
      @(negedge I_clk); #1; k++;
    end
    check_val("done_seen", n_done - base_done, 1);
    repeat (3) @(negedge I_clk);
    #1;
    check_val("done_once", n_done - base_done, 1);
    check_val("rd_count", n_rd - base_rd, cur_len);
    check_val("xfer_count", n_xfer - base_x, cur_len);
    check_val("busy_idle", longint'(O_busy), 0);
  endtask

  task automatic fill_ram(input int len);
    int v;
    for (int i = 0; i < len; i++) begin
      if ($urandom_range(0, 1) == 1) v = int'($urandom_range(0, 600)) - 300;
      else v = int'($urandom) >>> 8;
      ram[i] = v[DS-1:0];
    end
  endtask

  task automatic check_all_zero(input string pfx);
    check_val({pfx, "_rd_en"}, longint'(O_rd_en), 0);
    check_val({pfx, "_raddr"}, longint'(O_raddr), 0);
    check_val({pfx, "_dv"},    longint'(O_dv), 0);
    check_val({pfx, "_dout"},  longint'(O_dout), 0);
    check_val({pfx, "_busy"},  longint'(O_busy), 0);
    check_val({pfx, "_done"},  longint'(O_done), 0);
  endtask

  initial begin
    int len, k;
    repeat (3) @(negedge I_clk);
    check_all_zero("reset");
    @(negedge I_clk); #1;
    I_rst_n = 1'b1;

    // T1: basic rounding shift, back-to-back beats, first-data latency
    ram[0] = 24'sd100; ram[1] = -24'sd100; ram[2] = 24'sd300; ram[3] = 24'sd5;
    rdy_mode = 0;
    start_drain(4, 2, 0);
    wait_done(200);
    check_val("t1_latency", first_dv_cyc - first_rd_cyc, LAT + 1);
    check_val("t1_back_to_back", last_xfer_cyc - first_dv_cyc, 3);
    check_val("t1_done_after_last", done_cyc - last_xfer_cyc, 1);

    // T2: saturation with ReLU, then round-half-up of 1.5
    ram[0] = -24'sd7; ram[1] = 24'sd1000; ram[2] = -24'sd1000;
    start_drain(3, 0, 1);
    wait_done(200);
    ram[0] = 24'sd24;
    start_drain(1, 4, 0);
    wait_done(200);

    // T3: random backpressure, random data/params; a start while busy must be ignored
    rdy_mode = 1;
    for (int it = 0; it < 4; it++) begin
      len = (it == 0) ? 16 : int'($urandom_range(1, 40));
      fill_ram(len);
      start_drain(len, int'($urandom_range(0, 20)), 1'($urandom_range(0, 1)));
      pulse_start(3, 1, !cur_relu);
      wait_done(3000);
    end

    // T4: output stalled from start; reads stop at FIFO depth plus the output register
    rdy_mode = 2;
    fill_ram(10);
    start_drain(10, 3, 0);
    repeat (20) @(negedge I_clk);
    #1;
    check_val("t4_stall_reads", n_rd - base_rd, DEPTH + 1);
    check_val("t4_dv_held", longint'(O_dv), 1);
    rdy_mode = 0;
    wait_done(300);

    // T5: zero-length drain, second start during DONE ignored
    cur_len = 0; base_rd = n_rd; base_x = n_xfer; base_done = n_done;
    @(posedge I_clk); #1;
    I_start = 1'b1; I_len = '0; start_cyc = cyc;
    @(posedge I_clk); #1;
    I_len = (AS+1)'(5);
    @(posedge I_clk); #1;
    I_start = 1'b0;
    repeat (6) @(negedge I_clk);
    #1;
    check_val("t5_done_once", n_done - base_done, 1);
    check_val("t5_no_reads", n_rd - base_rd, 0);
    check_val("t5_done_lat", longint'((done_cyc - start_cyc) >= 1 && (done_cyc - start_cyc) <= 2), 1);
    check_val("t5_busy_idle", longint'(O_busy), 0);

    // T6: reset in the middle of a drain, then a clean restart
    fill_ram(8);
    start_drain(8, 1, 0);
    k = 0;
    while ((n_xfer - base_x) < 3 && k < 200) begin
      @(negedge I_clk); #1; k++;
    end
    check_val("t6_reached_beats", longint'((n_xfer - base_x) >= 3), 1);
    @(posedge I_clk); #2;
    I_rst_n = 1'b0;
    #1;
    check_all_zero("t6_rst");
    repeat (2) @(negedge I_clk);
    #1;
    I_rst_n = 1'b1;
    check_val("t6_no_done", n_done - base_done, 0);
    ram[0] = 24'sd1234; ram[1] = -24'sd55;
    start_drain(2, 0, 0);
    wait_done(200);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
